// File: rtl/fifo_mac_pkg.sv
// Shared types and default widths for the dual-FIFO multiply-accumulate reader.
package fifo_mac_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefDepth     = 8;
    localparam int unsigned DefAccWidth  = 24;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/fifo_mac_reader_if.sv
// Read-side handshake of the two operand FIFOs (A and B).
interface fifo_mac_reader_if
    import fifo_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth
);
    logic                  a_empty;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_rden;
    logic                  b_empty;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_rden;

    // Reader side.
    modport master (
        input  a_empty, a_rdata, b_empty, b_rdata,
        output a_rden, b_rden
    );

    // FIFO side.
    modport slave (
        output a_empty, a_rdata, b_empty, b_rdata,
        input  a_rden, b_rden
    );
endinterface

// File: rtl/mac_unit.sv
// Unsigned multiply plus wrapping accumulate register.
module mac_unit
    import fifo_mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ACC_WIDTH  = DefAccWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);
    localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

    logic [ProdWidth-1:0] prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_q;

    assign prod     = a * b;
    // Size cast zero-extends or truncates depending on the relative widths.
    assign prod_ext = ACC_WIDTH'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (valid) begin
            acc_q <= acc_q + prod_ext;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fifo_mac_reader.sv
// Pops FIFOs A and B in lockstep for DEPTH pairs per start and accumulates each product.
module fifo_mac_reader
    import fifo_mac_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DefDataWidth,
    parameter  int unsigned DEPTH      = DefDepth,
    parameter  int unsigned ACC_WIDTH  = DefAccWidth,
    localparam int unsigned CntWidth   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clr,
    fifo_mac_reader_if.master    fifo,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 busy,
    output logic                 done,
    output logic [CntWidth-1:0]  pairs
);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(DEPTH);
    localparam logic [CntWidth-1:0] LastPop  = CntWidth'(DEPTH - 1);
    localparam logic [CntWidth-1:0] One      = CntWidth'(1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] pops_q, pops_d;
    logic [CntWidth-1:0] pairs_q;
    logic                valid_q;
    logic                pop;
    logic                acc_clr;

    always_comb begin
        state_d = state_q;
        pops_d  = pops_q;
        pop     = 1'b0;
        acc_clr = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    pops_d  = '0;
                    acc_clr = 1'b1;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (!fifo.a_empty && !fifo.b_empty && (pops_q < DepthCnt)) begin
                    pop    = 1'b1;
                    pops_d = pops_q + One;
                    if (pops_q == LastPop) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The final pop happened in the last RUN cycle, so its pair lands on this edge.
                busy    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    state_d = StRun;
                    pops_d  = '0;
                    acc_clr = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clr) begin
            state_d = StIdle;
            pops_d  = '0;
            pop     = 1'b0;
            acc_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pops_q  <= '0;
            valid_q <= 1'b0;
            pairs_q <= '0;
        end else begin
            state_q <= state_d;
            pops_q  <= pops_d;
            valid_q <= pop && !clr;
            if (acc_clr) begin
                pairs_q <= '0;
            end else if (valid_q) begin
                pairs_q <= pairs_q + One;
            end
        end
    end

    // Clearing wins inside the MAC, so a pair in flight during clr is dropped.
    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .valid(valid_q),
        .clr  (acc_clr),
        .a    (fifo.a_rdata),
        .b    (fifo.b_rdata),
        .acc  (result)
    );

    assign fifo.a_rden = pop;
    assign fifo.b_rden = pop;
    assign pairs       = pairs_q;

endmodule

// File: doc/fifo_mac_reader.md
Name: fifo_mac_reader

Overview:
- Reader end of the dual-FIFO datapath: pops operand FIFOs A and B in lockstep and multiply-accumulates each pair.
- Runs exactly DEPTH pairs per `start`, then holds the final sum for the HEX display logic at top level.
- Connects to standard one-cycle-latency (non-showahead) FIFOs.

Parameters:
- DATA_WIDTH, 8: width of each FIFO operand, unsigned.
- DEPTH, 8: number of operand pairs consumed per run.
- ACC_WIDTH, 24: accumulator and result width.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle or done.
- clr  in  1  synchronous clear of accumulator and state.
- a_empty  in  1  FIFO A empty flag.
- a_rdata  in  DATA_WIDTH  FIFO A read data, valid one cycle after a_rden.
- a_rden  out  1  FIFO A read request.
- b_empty  in  1  FIFO B empty flag.
- b_rdata  in  DATA_WIDTH  FIFO B read data, valid one cycle after b_rden.
- b_rden  out  1  FIFO B read request.
- result  out  ACC_WIDTH  accumulated sum.
- busy  out  1  run in progress.
- done  out  1  run complete; result final.
- pairs  out  $clog2(DEPTH+1)  pairs accumulated so far.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; acc, pairs and the valid pipe bit are all 0.
  - a_rden, b_rden, busy and done are 0.
  - Mid-run reset aborts immediately. No further rden. Accumulated data is lost.
- States:
  - IDLE: start goes to RUN; pops counter set to 0.
  - RUN: busy=1.
    - a_rden = b_rden = 1 when both FIFOs are non-empty and pops < DEPTH. The two are always equal (lockstep pop).
    - If either FIFO is empty, neither is read (stall). The run waits indefinitely.
    - Each pop increments pops.
    - When pops reaches DEPTH, go to DRAIN.
  - DRAIN: busy=1, no rden. Wait for the last valid pair to accumulate, then go to DONE.
  - DONE: done=1, busy=0, result held.
    - start: acc cleared, pairs cleared, go to RUN.
    - clr: go to IDLE.
- Read pipeline:
  - valid_q is set the cycle after a pop.
  - When valid_q=1: acc <= acc + a_rdata*b_rdata.
  - Product is 2*DATA_WIDTH bits, zero-extended or truncated to ACC_WIDTH.
  - Addition wraps modulo 2^ACC_WIDTH. No saturation.
  - pairs increments with each accumulation.
- Latency:
  - With FIFOs pre-filled, first rden is in the cycle after start.
  - Last rden is DEPTH cycles later.
  - done rises 2 cycles after the last rden cycle.
  - Total: start at cycle 0 gives done=1 at cycle DEPTH+2.
- result is a direct register output equal to acc, updated in the same cycle as acc.
- clr:
  - Any state goes to IDLE. acc=0, pairs=0, valid_q=0. rden is deasserted that cycle.
  - clr takes priority over start in the same cycle.
  - A read issued the cycle before clr is discarded (its data is not accumulated).
- start while in RUN or DRAIN is ignored.
- Empty flags that assert between the rden cycle and the data cycle have no effect; the in-flight pair is still accumulated.

Decomposition:
- Package fifo_mac_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - default width localparams.
- One sub-module, mac_unit: unsigned multiply plus accumulate register.
  - Inputs: valid, a, b, clr.
  - Output: acc.
- Control FSM and pop counter stay in fifo_mac_reader.

Test Plan:
- Basic run: FIFOs pre-filled A=1..8, B=1..8, start pulse. Expect result=204 (0x0000CC), pairs=8, done high at start+10 cycles, exactly 8 rden pulses on each FIFO.
- Max-value run: A=B=255 for all 8 entries. Expect result=520200 (0x07F008), no wrap.
- Stall: B holds only 3 entries, A holds 8. Expect 3 pops, then a_rden=b_rden=0 while B is empty and busy remains 1. Pushing the remaining 5 B entries later resumes the run and finishes at result=204.
- clr mid-run: assert clr after 4 pops. Next cycle expects IDLE, result=0, pairs=0, no rden. A new start with refilled FIFOs yields 204.
- Reset mid-run: drop rst_n asynchronously, mid-cycle, during DRAIN. Outputs go to 0 immediately without waiting for a clock edge; done=0 after rst_n releases.
- start while busy: pulse start at cycle 3 of a run. Expect no restart, exactly 8 pops, result=204. start in DONE restarts from acc=0.
